// File: rtl/hier_rr_arbiter_pkg.sv
// Shared types and sizing helpers for the hierarchical round-robin arbiter.
package hier_arb_pkg;

    localparam int MAX_REQ = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Index width that stays at least one bit so a single requester still has an id port.
    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hier_rr_arbiter_if.sv
// Request/grant/result bundle between requesters (master) and the arbiter (slave).
interface hier_rr_arbiter_if
    import hier_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 1
) ();

    localparam int IW = id_width(NUM_REQ);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;
    logic                      busy;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_data;
    logic [IW-1:0]             out_id;

    modport master (
        output req, req_data,
        input  gnt, busy, out_valid, out_data, out_id
    );

    modport slave (
        input  req, req_data,
        output gnt, busy, out_valid, out_data, out_id
    );

endinterface

// File: rtl/hier_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from ptr, with wrap.
module rr_pick
    import hier_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]            req,
    input  logic [id_width(NUM_REQ)-1:0]  ptr,
    input  logic [NUM_REQ-1:0]            exclude,
    output logic                          found,
    output logic [id_width(NUM_REQ)-1:0]  index
);

    localparam int IW = id_width(NUM_REQ);

    logic [NUM_REQ-1:0] cand;

    assign cand = req & ~exclude;

    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && cand[(int'(ptr) + i) % NUM_REQ]) begin
                found = 1'b1;
                index = IW'((int'(ptr) + i) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/hier_rr_arbiter.sv
// Round-robin arbiter with per-grant burst limit sharing one registered inverting stage.
//   state | meaning
//   IDLE  | no grant held; any request is granted on the next edge
//   GRANT | gnt[owner] held; transfers each cycle req[owner] stays high
module hier_rr_arbiter
    import hier_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 1,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    hier_rr_arbiter_if.slave  bus
);

    localparam int IW = id_width(NUM_REQ);
    localparam int BW = (MAX_BURST <= 1) ? 1 : $clog2(MAX_BURST);

    state_t             state;
    logic [IW-1:0]      ptr;
    logic [IW-1:0]      owner;
    logic [BW-1:0]      burst_cnt;

    logic [NUM_REQ-1:0] own_oh;
    logic [DATA_W-1:0]  own_data;
    logic               xfer;
    logic               others;
    logic               last;
    logic               release_now;
    logic [IW-1:0]      owner_inc;
    logic [IW-1:0]      pick_ptr;
    logic [NUM_REQ-1:0] pick_excl;
    logic               pick_found;
    logic [IW-1:0]      pick_idx;

    assign own_oh      = NUM_REQ'(1) << owner;
    assign own_data    = bus.req_data[int'(owner)*DATA_W +: DATA_W];
    assign xfer        = (state == GRANT) && bus.req[owner];
    assign others      = |(bus.req & ~own_oh);
    assign last        = (burst_cnt == BW'(MAX_BURST - 1));
    assign release_now = (state == GRANT) && (!bus.req[owner] || (last && others));
    assign owner_inc   = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + IW'(1);

    // While granted, the picker already looks past the owner so a release can hand over in the same edge.
    assign pick_ptr  = (state == GRANT) ? owner_inc : ptr;
    assign pick_excl = (state == GRANT) ? own_oh : '0;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req     (bus.req),
        .ptr     (pick_ptr),
        .exclude (pick_excl),
        .found   (pick_found),
        .index   (pick_idx)
    );

    assign bus.busy = (state == GRANT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            ptr           <= '0;
            owner         <= '0;
            burst_cnt     <= '0;
            bus.gnt       <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_id    <= '0;
        end else begin
            bus.out_valid <= 1'b0;
            if (xfer) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= ~own_data;
                bus.out_id    <= owner;
            end
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        bus.gnt   <= NUM_REQ'(1) << pick_idx;
                        owner     <= pick_idx;
                        burst_cnt <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        ptr       <= owner_inc;
                        burst_cnt <= '0;
                        if (pick_found) begin
                            bus.gnt <= NUM_REQ'(1) << pick_idx;
                            owner   <= pick_idx;
                        end else begin
                            bus.gnt <= '0;
                            state   <= IDLE;
                        end
                    end else if (last) begin
                        burst_cnt <= '0;
                    end else begin
                        burst_cnt <= burst_cnt + BW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hier_rr_arbiter.sv
// Directed bench for hier_rr_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_hier_rr_arbiter;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    hier_rr_arbiter_if #(.NUM_REQ(4), .DATA_W(1)) bus ();

    hier_rr_arbiter #(.NUM_REQ(4), .DATA_W(1), .MAX_BURST(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic [3:0] data;
        logic [3:0] gnt;
        logic       valid;
        logic       odata;
        logic [1:0] id;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] d,
                       input logic [3:0] g, input logic v, input logic od, input logic [1:0] id);
        vec_t t;
        t.rst_n = r; t.req = rq; t.data = d; t.gnt = g; t.valid = v; t.odata = od; t.id = id;
        vecs.push_back(t);
    endtask

    task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] d);
        rst_n        = r;
        bus.req      = rq;
        bus.req_data = d;
        tick();
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input logic v,
                           input logic od, input logic [1:0] id);
        chk({tag, "_gnt"},   32'(bus.gnt),       32'(g));
        chk({tag, "_busy"},  32'(bus.busy),      32'(|g));
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
        chk({tag, "_data"},  32'(bus.out_data),  32'(od));
        chk({tag, "_id"},    32'(bus.out_id),    32'(id));
    endtask

    int id1_pulses;

    initial begin
        rst_n        = 1'b0;
        bus.req      = '0;
        bus.req_data = '0;

        // reset, then burst limit with req=1001 starting from ptr=0
        add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        add(1, 4'b1001, 4'b0000, 4'b0001, 0, 0, 0);
        add(1, 4'b1001, 4'b1000, 4'b0001, 1, 1, 0);
        add(1, 4'b1001, 4'b0001, 4'b0001, 1, 0, 0);
        add(1, 4'b1001, 4'b1001, 4'b0001, 1, 0, 0);
        add(1, 4'b1001, 4'b1000, 4'b1000, 1, 1, 0);
        add(1, 4'b1001, 4'b0001, 4'b1000, 1, 1, 3);
        add(1, 4'b1001, 4'b1000, 4'b1000, 1, 0, 3);
        add(1, 4'b1001, 4'b1001, 4'b1000, 1, 0, 3);
        add(1, 4'b1001, 4'b0001, 4'b0001, 1, 1, 3);
        add(1, 4'b1001, 4'b1000, 4'b0001, 1, 1, 0);
        // single requester 1: owner 0 drops, grant hands over directly, never released
        add(1, 4'b0010, 4'b0010, 4'b0010, 0, 1, 0);
        for (int i = 0; i < 5; i++) add(1, 4'b0010, 4'b0010, 4'b0010, 1, 0, 1);
        add(1, 4'b0010, 4'b0000, 4'b0010, 1, 1, 1);
        // all idle: outputs hold last result
        for (int i = 0; i < 5; i++) add(1, 4'b0000, 4'b0000, 4'b0000, 0, 1, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst_n, vecs[i].req, vecs[i].data);
            chk_out($sformatf("v%0d", i), vecs[i].gnt, vecs[i].valid, vecs[i].odata, vecs[i].id);
        end

        // wrap-around: ptr=2 now; grant 2, release it so ptr=3, then req=0101 must pick 0 first
        drive(1, 4'b0100, 4'b0000);
        chk_out("wrap_g2", 4'b0100, 0, 1, 1);
        drive(1, 4'b0100, 4'b0100);
        chk_out("wrap_x2", 4'b0100, 1, 0, 2);
        drive(1, 4'b0000, 4'b0000);
        chk_out("wrap_rel", 4'b0000, 0, 0, 2);
        drive(1, 4'b0101, 4'b0000);
        chk_out("wrap_pick0", 4'b0001, 0, 0, 2);
        for (int i = 0; i < 4; i++) begin
            drive(1, 4'b0101, 4'b0000);
            chk_out($sformatf("wrap_b%0d", i), (i == 3) ? 4'b0100 : 4'b0001, 1, 1, 0);
        end

        // reset mid-burst with owner 2 transferring
        drive(1, 4'b0100, 4'b0000);
        chk_out("mid_x2", 4'b0100, 1, 1, 2);
        drive(0, 4'b0100, 4'b0000);
        chk_out("mid_rst", 4'b0000, 0, 0, 0);
        drive(1, 4'b0100, 4'b0000);
        chk_out("mid_regrant", 4'b0100, 0, 0, 0);

        // early release: owner 1 drops after 2 transfers while 3 waits
        drive(0, 4'b0000, 4'b0000);
        drive(1, 4'b0010, 4'b0000);
        chk_out("early_g1", 4'b0010, 0, 0, 0);
        id1_pulses = 0;
        for (int i = 0; i < 4; i++) begin
            if (i < 2)       drive(1, 4'b1010, 4'b0010);
            else             drive(1, 4'b1000, 4'b0000);
            if (bus.out_valid && bus.out_id == 2'd1) id1_pulses++;
            if (i == 1) chk("early_gnt_hold", 32'(bus.gnt), 32'(4'b0010));
            if (i == 2) chk_out("early_switch", 4'b1000, 0, 0, 1);
            if (i == 3) chk_out("early_x3", 4'b1000, 1, 1, 3);
        end
        chk("early_id1_pulses", 32'(id1_pulses), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hier_rr_arbiter.md
Name: hier_rr_arbiter

Overview:
- Round-robin arbiter that shares one registered inverting datapath stage between NUM_REQ requesters.
- Grants one requester at a time and enforces a per-grant burst limit.
- Tags each result with the winning requester index.
- Sits above the leaf/level hierarchy as its sequencer and serves as the sequential hierarchy test design for timing and netlist traversal.

Parameters:
- NUM_REQ, 4: number of requesters, 1..8.
- DATA_W, 1: width of each requester's data and of the result.
- MAX_BURST, 4: maximum consecutive transfers per grant while another requester waits, at least 1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- req  input  NUM_REQ  per-requester request level.
- req_data  input  NUM_REQ*DATA_W  packed data; requester i occupies bits [i*DATA_W +: DATA_W].
- gnt  output  NUM_REQ  registered one-hot grant; all-zero when idle.
- busy  output  1  high while in GRANT state.
- out_valid  output  1  one-cycle pulse, one cycle after each transfer.
- out_data  output  DATA_W  bitwise inverse of the transferred data.
- out_id  output  clog2(NUM_REQ), min 1  index of the requester that produced out_data.

Behaviour:
- Reset: rst_n low at a rising edge clears the following on that edge, including mid-burst. Any in-flight transfer is dropped.
  - gnt=0, busy=0, out_valid=0, out_data=0, out_id=0
  - state=IDLE, priority pointer ptr=0, burst_cnt=0
- Pick function: first i with req[i]=1, scanning ptr, ptr+1, ... modulo NUM_REQ. Wraps from NUM_REQ-1 to 0.
- IDLE state:
  - If any req is high, register gnt=onehot(pick), owner=pick, burst_cnt=0, go to GRANT.
  - Request-to-grant latency is 1 cycle. No transfer occurs in IDLE.
- GRANT state, transfer rule:
  - A transfer occurs in a cycle with gnt[owner]=1 and req[owner]=1.
  - On that edge the shared stage captures out_data=~req_data[owner], out_id=owner, out_valid=1 for the next cycle only.
  - Throughput is 1 transfer per cycle. Data-to-result latency is 1 cycle.
- GRANT state, release conditions, evaluated on each edge:
  - (a) req[owner]=0: no transfer. Release.
  - (b) Transfer with burst_cnt==MAX_BURST-1 and some other req[j]=1 (j != owner): release after this transfer.
  - (c) Transfer with burst_cnt==MAX_BURST-1 and no other request: keep grant, burst_cnt=0.
  - Otherwise: on a transfer, burst_cnt++.
- On release:
  - ptr=(owner+1) mod NUM_REQ.
  - Re-pick among current req, excluding the owner in case (b).
  - If a winner exists, gnt switches directly to it with no idle cycle and burst_cnt=0.
  - Otherwise go to IDLE with gnt=0.
- A requester dropping req and re-raising it later waits for its round-robin turn.
- Invariants:
  - gnt is always one-hot or zero.
  - busy equals |gnt.
  - out_valid never asserts without a transfer on the preceding edge.
- NUM_REQ=1: out_id is a constant 0. Case (b) never fires.
- req_data of non-owners is ignored. Changes to req while idle take effect on the next edge.

Decomposition:
- Package hier_arb_pkg holds:
  - state enum {IDLE, GRANT}
  - function id_width(n) returning max(1, clog2(n))
  - MAX_REQ=8 limit constant
- One sub-module, rr_pick.
  - Combinational.
  - Inputs: req vector, ptr, exclude mask.
  - Outputs: found, index.
  - The top instantiates it once, keeping the hierarchical depth for dbSta traversal checks.
- The shared inverting stage stays inline in the top.

Test Plan:
- Reset mid-burst: owner 2 transferring, rst_n=0 for 1 edge. Next cycle gnt=0, out_valid=0, out_id=0, busy=0. After rst_n=1 with req=4'b0100, gnt=4'b0100 one cycle later.
- Single requester: req=4'b0010, data=1 held for 6 cycles. gnt=4'b0010 from cycle 1. out_valid high cycles 2..7 with out_data=0, out_id=1. Grant is never dropped (case c).
- Burst limit: req=4'b1001 constant, MAX_BURST=4. Transfers go to owner 0 for 4 cycles, then gnt=4'b1000 with no gap, 4 transfers, then back to 4'b0001. out_id sequence is 0,0,0,0,3,3,3,3,0.
- Wrap-around: ptr=3 after release of 2, req=4'b0101. Pick yields 0 (wrap), then 2. Never 2 twice in a row.
- Early release: owner 1 drops req after 2 transfers while req[3]=1. gnt goes 4'b0010 then 4'b1000 on the next edge. Exactly 2 out_valid pulses carry out_id=1.
- All idle: req=0 for 5 cycles after a grant. gnt=0, busy=0, out_valid=0. out_data and out_id hold their last values.
